// File: rtl/instruction_loader.sv
// Boot loader: turns a HDR/{HI,LO}.../[CHK] byte stream into sequential instruction-memory writes.
// Optional trailing checksum byte enabled by defining INSTRUCTION_LOADER_CHECKSUM_EN.
module instruction_loader #(
    parameter int INSTRUCTION_WIDTH = 10,
    parameter int ADDR_BITS         = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    output logic                         mem_we,
    output logic [ADDR_BITS-1:0]         mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int HI_W = INSTRUCTION_WIDTH - 8;

    typedef enum logic [2:0] {
        s_idle, s_hdr, s_hi, s_lo, s_wr, s_chk, s_done
    } state_t;

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] count;
    logic [ADDR_BITS-1:0] addr;
    logic [HI_W-1:0]      hi_byte;
    logic                 xfer;

    assign xfer = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= s_idle;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            s_idle: begin
                busy = 1'b0;
                if (start) state_nxt = s_hdr;
            end
            s_hdr: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = s_hi;
            end
            s_hi: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = s_lo;
            end
            s_lo: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = s_wr;
            end
            s_wr: begin
                mem_we = 1'b1;
                if (addr == count) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    state_nxt = s_chk;
`else
                    state_nxt = s_done;
`endif
                end else begin
                    state_nxt = s_hi;
                end
            end
            s_chk: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = s_done;
            end
            s_done: begin
                done      = 1'b1;
                state_nxt = s_idle;
            end
            default: state_nxt = s_idle;
        endcase
    end

    // Word address/count and the pending high byte; always initialised by the header before use.
    always_ff @(posedge clk) begin
        if (state == s_hdr && xfer) begin
            count <= in_data[ADDR_BITS-1:0];
            addr  <= '0;
        end else if (state == s_wr && addr != count) begin
            addr <= addr + ADDR_BITS'(1);
        end
        if (state == s_hi && xfer) hi_byte <= in_data[HI_W-1:0];
    end

    // Write port registers load on the LO byte so they are stable through WR and hold afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == s_lo && xfer) begin
            mem_addr  <= addr;
            mem_wdata <= {hi_byte, in_data};
        end
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0] chk_acc;

    always_ff @(posedge clk) begin
        if (state == s_hdr && xfer)                      chk_acc <= in_data;
        else if ((state == s_hi || state == s_lo) && xfer) chk_acc <= chk_acc ^ in_data;
    end

    // Sticky until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n)                                       error <= 1'b0;
        else if (state == s_idle && start)                error <= 1'b0;
        else if (state == s_chk && xfer && in_data != chk_acc) error <= 1'b1;
    end
`else
    assign error = 1'b0;
`endif

endmodule
